// File: rtl/bip_dp_pkg.sv
// Shared widths, ALU opcodes, write-source encodings and flag bit positions
// for the BIP accumulator-bank datapath.
package bip_dp_pkg;

    localparam int unsigned NB_DATA    = 16;
    localparam int unsigned NB_IMM     = 11;
    localparam int unsigned N_ACC      = 4;
    localparam int unsigned LOG2_N_ACC = 2;
    localparam int unsigned NB_FLAGS   = 4;
    localparam int unsigned NB_OP      = 3;
    localparam int unsigned NB_SEL_A   = 2;

    localparam int unsigned FLAG_V = 3;
    localparam int unsigned FLAG_C = 2;
    localparam int unsigned FLAG_N = 1;
    localparam int unsigned FLAG_Z = 0;

    typedef enum logic [NB_OP-1:0] {
        OP_SUB   = 3'b000,
        OP_ADD   = 3'b001,
        OP_AND   = 3'b010,
        OP_OR    = 3'b011,
        OP_XOR   = 3'b100,
        OP_SHL1  = 3'b101,
        OP_SRA1  = 3'b110,
        OP_PASSB = 3'b111
    } alu_op_e;

    typedef enum logic [NB_SEL_A-1:0] {
        SEL_A_MEM  = 2'b00,
        SEL_A_IMM  = 2'b01,
        SEL_A_ALU  = 2'b10,
        SEL_A_HOLD = 2'b11
    } sel_a_e;

    function automatic logic [NB_DATA-1:0] sext_imm(input logic [NB_IMM-1:0] imm);
        return {{(NB_DATA - NB_IMM){imm[NB_IMM-1]}}, imm};
    endfunction

endpackage

// File: rtl/bip_acc_bank_datapath_if.sv
// Control-unit / data-memory side bus of the accumulator-bank datapath.
interface bip_acc_bank_datapath_if;
    import bip_dp_pkg::*;

    logic                  i_valid;
    logic [NB_IMM-1:0]     i_imm;
    logic [NB_DATA-1:0]    i_data_mem;
    logic [NB_SEL_A-1:0]   i_sel_a;
    logic                  i_sel_b;
    logic                  i_wr_acc;
    logic [NB_OP-1:0]      i_alu_op;
    logic [LOG2_N_ACC-1:0] i_acc_sel;
    logic [NB_DATA-1:0]    o_data;
    logic [NB_FLAGS-1:0]   o_flags;
    logic                  o_commit;

    modport master (
        output i_valid, i_imm, i_data_mem, i_sel_a, i_sel_b, i_wr_acc, i_alu_op, i_acc_sel,
        input  o_data, o_flags, o_commit
    );

    modport slave (
        input  i_valid, i_imm, i_data_mem, i_sel_a, i_sel_b, i_wr_acc, i_alu_op, i_acc_sel,
        output o_data, o_flags, o_commit
    );

endinterface

// File: rtl/bip_dp_alu.sv
// Combinational 8-operation ALU producing the result and {V,C,N,Z}.
module bip_dp_alu
    import bip_dp_pkg::*;
(
    input  logic [NB_DATA-1:0]  a,
    input  logic [NB_DATA-1:0]  b,
    input  alu_op_e             op,
    output logic [NB_DATA-1:0]  result,
    output logic [NB_FLAGS-1:0] flags
);

    localparam int unsigned MSB = NB_DATA - 1;

    logic [NB_DATA:0] sum_c;
    logic [NB_DATA:0] diff_c;
    logic             carry_c;
    logic             ovf_c;

    // Carry/borrow come from the extra bit of a zero-extended add/subtract.
    always_comb begin
        sum_c   = {1'b0, a} + {1'b0, b};
        diff_c  = {1'b0, a} - {1'b0, b};
        result  = '0;
        carry_c = 1'b0;
        ovf_c   = 1'b0;
        case (op)
            OP_SUB: begin
                result  = diff_c[MSB:0];
                carry_c = diff_c[NB_DATA];
                ovf_c   = (a[MSB] != b[MSB]) && (diff_c[MSB] != a[MSB]);
            end
            OP_ADD: begin
                result  = sum_c[MSB:0];
                carry_c = sum_c[NB_DATA];
                ovf_c   = (a[MSB] == b[MSB]) && (sum_c[MSB] != a[MSB]);
            end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SHL1: begin
                result  = {a[MSB-1:0], 1'b0};
                carry_c = a[MSB];
            end
            OP_SRA1: begin
                result  = {a[MSB], a[MSB:1]};
                carry_c = a[0];
            end
            default: result = b;
        endcase
    end

    always_comb begin
        flags         = '0;
        flags[FLAG_V] = ovf_c;
        flags[FLAG_C] = carry_c;
        flags[FLAG_N] = result[MSB];
        flags[FLAG_Z] = (result == '0);
    end

endmodule

// File: rtl/bip_acc_bank_datapath.sv
// Two-stage BIP datapath: E1 instruction registers, E2 accumulator bank write with bypass.
// Define BIP_DP_FLAGS_EN to build the registered {V,C,N,Z} flag word.
module bip_acc_bank_datapath
    import bip_dp_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    bip_acc_bank_datapath_if.slave  bus
);

    logic                  v_q;
    logic                  wr_acc_q;
    sel_a_e                sel_a_q;
    alu_op_e               alu_op_q;
    logic [LOG2_N_ACC-1:0] idx_q;
    logic [NB_DATA-1:0]    b_q;
    logic [NB_DATA-1:0]    imm_q;
    logic [NB_DATA-1:0]    mem_q;

    logic [NB_DATA-1:0]    acc [N_ACC];
    logic                  commit_q;

    logic [NB_DATA-1:0]    a_c;
    logic [NB_DATA-1:0]    alu_result_c;
    logic [NB_FLAGS-1:0]   alu_flags_c;
    logic [NB_DATA-1:0]    wr_value_c;
    logic                  wr_en_c;

    // E1: capture the issued instruction; a reset edge drops it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            v_q      <= 1'b0;
            wr_acc_q <= 1'b0;
            sel_a_q  <= SEL_A_HOLD;
            alu_op_q <= OP_SUB;
            idx_q    <= '0;
            b_q      <= '0;
            imm_q    <= '0;
            mem_q    <= '0;
        end else begin
            v_q <= bus.i_valid;
            if (bus.i_valid) begin
                wr_acc_q <= bus.i_wr_acc;
                sel_a_q  <= sel_a_e'(bus.i_sel_a);
                alu_op_q <= alu_op_e'(bus.i_alu_op);
                idx_q    <= bus.i_acc_sel;
                imm_q    <= sext_imm(bus.i_imm);
                mem_q    <= bus.i_data_mem;
                b_q      <= bus.i_sel_b ? sext_imm(bus.i_imm) : bus.i_data_mem;
            end
        end
    end

    assign a_c = acc[idx_q];

    bip_dp_alu u_alu (
        .a      (a_c),
        .b      (b_q),
        .op     (alu_op_q),
        .result (alu_result_c),
        .flags  (alu_flags_c)
    );

    always_comb begin
        wr_value_c = a_c;
        case (sel_a_q)
            SEL_A_MEM: wr_value_c = mem_q;
            SEL_A_IMM: wr_value_c = imm_q;
            SEL_A_ALU: wr_value_c = alu_result_c;
            default:   wr_value_c = a_c;
        endcase
    end

    assign wr_en_c = v_q && wr_acc_q && (sel_a_q != SEL_A_HOLD);

    // E2: bank write and commit pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int unsigned i = 0; i < N_ACC; i++) begin
                acc[i] <= '0;
            end
            commit_q <= 1'b0;
        end else begin
            commit_q <= wr_en_c;
            if (wr_en_c) begin
                acc[idx_q] <= wr_value_c;
            end
        end
    end

`ifdef BIP_DP_FLAGS_EN
    logic [NB_FLAGS-1:0] flags_q;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            flags_q <= '0;
        end else if (wr_en_c && (sel_a_q == SEL_A_ALU)) begin
            flags_q <= alu_flags_c;
        end
    end

    assign bus.o_flags = flags_q;
`else
    logic flags_unused_c;
    assign flags_unused_c = ^alu_flags_c;
    assign bus.o_flags    = '0;
`endif

    // Forward the in-flight write so reads see it before the bank edge.
    assign bus.o_data   = (wr_en_c && (idx_q == bus.i_acc_sel)) ? wr_value_c : acc[bus.i_acc_sel];
    assign bus.o_commit = commit_q;

endmodule

// File: tb/tb_bip_acc_bank_datapath.sv
// Scoreboard bench for bip_acc_bank_datapath: directed plan plus random instruction stream.
module tb_bip_acc_bank_datapath;
    import bip_dp_pkg::*;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    bip_acc_bank_datapath_if bus ();

    bip_acc_bank_datapath dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: architectural accumulators after every sampled instruction.
    logic [15:0] m_acc [4];
    logic [3:0]  m_flags = 4'b0000;
    logic [3:0]  exp_flags_q [$];
    bit          pend_write = 1'b0;
    bit          exp_commit = 1'b0;
    bit          mon_en = 1'b0;

    function automatic void ref_alu(input int op, input int a, input int b,
                                    output int res, output logic [3:0] fl);
        int sa, sb, full;
        bit c, v;
        sa = (a >= 32768) ? a - 65536 : a;
        sb = (b >= 32768) ? b - 65536 : b;
        c = 1'b0;
        v = 1'b0;
        full = 0;
        case (op)
            0: begin full = a - b; c = (a < b); v = (sa - sb > 32767) || (sa - sb < -32768); end
            1: begin full = a + b; c = (full > 65535); v = (sa + sb > 32767) || (sa + sb < -32768); end
            2: full = a & b;
            3: full = a | b;
            4: full = a ^ b;
            5: begin full = a * 2; c = (a >= 32768); end
            6: begin full = (sa - (sa & 1)) / 2; c = ((a % 2) == 1); end
            default: full = b;
        endcase
        res = full & 32'hFFFF;
        fl = {v, c, (res >= 32768), (res == 0)};
    endfunction

    task automatic apply_model(input bit v, input int imm, input int mem, input int sa,
                               input bit sb, input bit wr, input int op, input int sel, input bit rst);
        int se, a, bv, res, nv;
        logic [3:0] fl;
        exp_commit = !rst && pend_write;
        if (rst) begin
            for (int i = 0; i < 4; i++) m_acc[i] = 16'h0000;
            m_flags = 4'b0000;
            exp_flags_q.delete();
            pend_write = 1'b0;
        end else begin
            pend_write = v && wr && (sa != 3);
            if (pend_write) begin
                se = (imm >= 1024) ? imm + 63488 : imm;
                a  = int'(m_acc[sel]);
                bv = sb ? se : mem;
                ref_alu(op, a, bv, res, fl);
                nv = (sa == 0) ? mem : (sa == 1) ? se : res;
                m_acc[sel] = 16'(nv);
`ifdef BIP_DP_FLAGS_EN
                if (sa == 2) m_flags = fl;
`endif
                exp_flags_q.push_back(m_flags);
            end
        end
    endtask

    task automatic step(input bit v, input int imm, input int mem, input int sa,
                        input bit sb, input bit wr, input int op, input int sel, input bit rst);
        bus.i_valid    = v;
        bus.i_imm      = 11'(imm);
        bus.i_data_mem = 16'(mem);
        bus.i_sel_a    = 2'(sa);
        bus.i_sel_b    = sb;
        bus.i_wr_acc   = wr;
        bus.i_alu_op   = 3'(op);
        bus.i_acc_sel  = 2'(sel);
        reset          = rst;
        @(posedge clock);
        apply_model(v, imm & 32'h7FF, mem & 32'hFFFF, sa, sb, wr, op, sel, rst);
        #1;
    endtask

    task automatic idle(input int sel);
        step(1'b0, 0, 0, 3, 1'b0, 1'b0, 0, sel, 1'b0);
    endtask

    task automatic expect_acc(input int sel, input logic [15:0] want, input string name);
        bus.i_valid   = 1'b0;
        bus.i_acc_sel = 2'(sel);
        #1;
        checks++;
        if (bus.o_data !== want) begin
            errors++;
            $display("FAIL %s: o_data[acc%0d] got=%h want=%h", name, sel, bus.o_data, want);
        end
    endtask

    task automatic expect_flags(input logic [3:0] want, input string name);
        checks++;
        if (bus.o_flags !== want) begin
            errors++;
            $display("FAIL %s: o_flags got=%b want=%b", name, bus.o_flags, want);
        end
    endtask

    // Monitor: per-cycle read/commit checks; flags popped from the scoreboard on each commit.
    initial begin
        logic [3:0] f;
        forever begin
            @(negedge clock);
            if (mon_en) begin
                checks++;
                if (bus.o_data !== m_acc[bus.i_acc_sel]) begin
                    errors++;
                    $display("FAIL read acc%0d: got=%h want=%h at %0t",
                             bus.i_acc_sel, bus.o_data, m_acc[bus.i_acc_sel], $time);
                end
                checks++;
                if (bus.o_commit !== exp_commit) begin
                    errors++;
                    $display("FAIL commit: got=%b want=%b at %0t", bus.o_commit, exp_commit, $time);
                end
                if (bus.o_commit === 1'b1) begin
                    checks++;
                    if (exp_flags_q.size() == 0) begin
                        errors++;
                        $display("FAIL commit_flags: got unexpected commit, want none at %0t", $time);
                    end else begin
                        f = exp_flags_q.pop_front();
                        if (bus.o_flags !== f) begin
                            errors++;
                            $display("FAIL commit_flags: got=%b want=%b at %0t", bus.o_flags, f, $time);
                        end
                    end
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) m_acc[i] = 16'h0000;
        reset = 1'b1;
        step(1'b0, 0, 0, 3, 1'b0, 1'b0, 0, 0, 1'b1);
        mon_en = 1'b1;
        step(1'b0, 0, 0, 3, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(0);
        for (int s = 0; s < 4; s++) expect_acc(s, 16'h0000, "reset_acc");
        expect_flags(4'b0000, "reset_flags");

        // Load 0x7FF sign-extends to 0xFFFF.
        step(1'b1, 11'h7FF, 0, 1, 1'b0, 1'b1, 0, 1, 1'b0);
        idle(0);
        expect_acc(1, 16'hFFFF, "load_imm_acc1");
        expect_acc(0, 16'h0000, "untouched_acc0");
        expect_acc(2, 16'h0000, "untouched_acc2");
        expect_acc(3, 16'h0000, "untouched_acc3");

        // Back-to-back chain on acc0: 5, +3, -9.
        step(1'b1, 5, 0, 1, 1'b0, 1'b1, 0, 0, 1'b0);
        step(1'b1, 3, 0, 2, 1'b1, 1'b1, 1, 0, 1'b0);
        step(1'b1, 0, 16'h0009, 2, 1'b0, 1'b1, 0, 0, 1'b0);
        idle(0);
        expect_acc(0, 16'hFFFF, "chain_acc0");
`ifdef BIP_DP_FLAGS_EN
        expect_flags(4'b0110, "chain_flags");
`else
        expect_flags(4'b0000, "chain_flags");
`endif

        // Signed overflow 0x7FFF + 1.
        step(1'b1, 0, 16'h7FFF, 0, 1'b0, 1'b1, 0, 2, 1'b0);
        step(1'b1, 1, 0, 2, 1'b1, 1'b1, 1, 2, 1'b0);
        idle(2);
        expect_acc(2, 16'h8000, "ovf_acc2");
`ifdef BIP_DP_FLAGS_EN
        expect_flags(4'b1010, "ovf_flags");
`else
        expect_flags(4'b0000, "ovf_flags");
`endif

        // Bypass: pending write to acc3 visible before its bank edge.
        step(1'b1, 0, 16'h1234, 0, 1'b0, 1'b1, 0, 3, 1'b0);
        expect_acc(3, 16'h1234, "bypass_acc3");
        expect_acc(0, 16'hFFFF, "bypass_other_acc0");
        idle(0);

        // Reset on the commit edge discards the pending load.
        step(1'b1, 7, 0, 1, 1'b0, 1'b1, 0, 0, 1'b0);
        step(1'b0, 0, 0, 3, 1'b0, 1'b0, 0, 0, 1'b1);
        idle(0);
        expect_acc(0, 16'h0000, "reset_discard_acc0");
        expect_flags(4'b0000, "reset_discard_flags");

        // Write enable low: no write, no commit.
        step(1'b1, 9, 0, 1, 1'b0, 1'b0, 0, 1, 1'b0);
        idle(1);
        expect_acc(1, 16'h0000, "no_wr_acc1");

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 7) != 0), int'($urandom_range(0, 2047)),
                 int'($urandom_range(0, 65535)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 5) != 0),
                 int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                 ($urandom_range(0, 49) == 0));
        end
        idle(0);
        idle(0);
        checks++;
        if (exp_flags_q.size() != 0) begin
            errors++;
            $display("FAIL drain: pending commits got=%0d want=0", exp_flags_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
